// File: rtl/sonar_ranger.sv
// sonar_ranger: HC-SR04 style trigger / echo-width controller timed by a sampled 1 MHz tick.
// Optional SONAR_AUTO_EN: ignore start and re-arm automatically after every holdoff.
module sonar_ranger #(
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000,
   parameter int HOLDOFF_US = 60000,
   parameter int W          = 16
) (
   input  logic         inclk,
   input  logic         rst,
   input  logic         clk_1m,
   input  logic         start,
   input  logic         echo,
   output logic         trig,
   output logic         busy,
   output logic         done,
   output logic         timeout,
   output logic [W-1:0] echo_us
);
   localparam logic [2:0] IDLE = 3'd0, TRIG = 3'd1, WAIT_RISE = 3'd2, MEASURE = 3'd3, HOLDOFF = 3'd4;
   localparam logic [W-1:0] TRIG_END = W'(TRIG_US - 1);
   localparam logic [W-1:0] TO_END   = W'(TIMEOUT_US - 1);
   localparam logic [W-1:0] TO_FULL  = W'(TIMEOUT_US);
   localparam logic [W-1:0] HO_END   = W'(HOLDOFF_US - 1);
   logic [2:0]   state;
   logic [W-1:0] cnt;
   logic         pend, c1, c2, e1, echo_s, tick;
   assign tick = c1 & ~c2;
   assign busy = state != IDLE;
   always_ff @(posedge inclk or posedge rst)
      if (rst) begin
         {c1, c2, e1, echo_s, pend, trig, done, timeout} <= '0;
         cnt     <= '0;
         echo_us <= '0;
         state   <= IDLE;
      end else begin
         c1     <= clk_1m;
         c2     <= c1;
         e1     <= echo;
         echo_s <= e1;
         done   <= 1'b0;
         case (state)
            IDLE: begin
`ifdef SONAR_AUTO_EN
               pend <= 1'b1;
`else
               if (start) pend <= 1'b1;
`endif
               if (pend && tick) begin
                  pend  <= 1'b0;
                  cnt   <= '0;
                  trig  <= 1'b1;
                  state <= TRIG;
               end
            end
            TRIG:
               if (tick) begin
                  if (cnt == TRIG_END) begin
                     trig  <= 1'b0;
                     cnt   <= '0;
                     state <= WAIT_RISE;
                  end else cnt <= cnt + 1'b1;
               end
            // echo is checked before the tick so a coincident tick never times out
            WAIT_RISE:
               if (echo_s) begin
                  cnt   <= '0;
                  state <= MEASURE;
               end else if (tick) begin
                  if (cnt == TO_END) begin
                     timeout <= 1'b1;
                     echo_us <= '0;
                     done    <= 1'b1;
                     cnt     <= '0;
                     state   <= HOLDOFF;
                  end else cnt <= cnt + 1'b1;
               end
            MEASURE:
               if (!echo_s) begin
                  echo_us <= cnt;
                  timeout <= 1'b0;
                  done    <= 1'b1;
                  cnt     <= '0;
                  state   <= HOLDOFF;
               end else if (tick) begin
                  if (cnt == TO_END) begin
                     echo_us <= TO_FULL;
                     timeout <= 1'b1;
                     done    <= 1'b1;
                     cnt     <= '0;
                     state   <= HOLDOFF;
                  end else cnt <= cnt + 1'b1;
               end
            HOLDOFF:
               if (tick) begin
                  if (cnt == HO_END) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else cnt <= cnt + 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_sonar_ranger.sv
// tb_sonar_ranger: directed checks of sonar_ranger with a 100:1 clk_1m ratio and shortened
// TIMEOUT/HOLDOFF so each run stays short; define SONAR_AUTO_EN to exercise the free-running build.
module tb_sonar_ranger;
   logic        inclk = 0, rst = 1, clk_1m = 0, start = 0, echo = 0;
   logic        trig, busy, done, timeout;
   logic [15:0] echo_us;
   int          errors = 0, checks = 0;
   int          n, seen;

   sonar_ranger #(.TRIG_US(10), .TIMEOUT_US(100), .HOLDOFF_US(50), .W(16)) dut (
      .inclk(inclk), .rst(rst), .clk_1m(clk_1m), .start(start), .echo(echo),
      .trig(trig), .busy(busy), .done(done), .timeout(timeout), .echo_us(echo_us)
   );

   always #5 inclk = ~inclk;
   always #500 clk_1m = ~clk_1m;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input logic [31:0] got, input int lo, input int hi);
      checks++;
      assert (got >= lo && got <= hi && !$isunknown(got)) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, got, lo, hi);
      end
   endtask

   task automatic wait_trig(input logic v, input int lim, output int k);
      k = 0;
      while (trig !== v && k < lim) begin
         @(negedge inclk);
         k++;
      end
   endtask

   task automatic wait_done(input int lim, output int k);
      k = 0;
      while (done !== 1'b1 && k < lim) begin
         @(negedge inclk);
         k++;
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy !== 1'b0 && k < 20000) begin
         @(negedge inclk);
         k++;
      end
      chk("return_idle", busy, 0);
   endtask

   task automatic pulse_start();
      @(negedge inclk);
      start = 1;
      @(negedge inclk);
      start = 0;
   endtask

   initial begin
      repeat (5) @(negedge inclk);
      chk("rst_trig", trig, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_echo_us", echo_us, 0);
      rst = 0;
      @(negedge inclk);
      chk("post_rst_busy", busy, 0);
`ifdef SONAR_AUTO_EN
      for (int i = 0; i < 2; i++) begin
         wait_trig(1, 8000, n);
         chk("auto_trig_rise", trig, 1);
         wait_trig(0, 2000, n);
         chk("auto_trig_width", n, 1000);
         repeat (500) @(negedge inclk);
         echo = 1;
         repeat (1000) @(negedge inclk);
         echo = 0;
         wait_done(500, n);
         chk("auto_done", done, 1);
         chk_rng("auto_echo_us", echo_us, 9, 10);
         chk("auto_timeout", timeout, 0);
      end
`else
      // normal echo: 20 us after trig falls, 58 us wide
      pulse_start();
      wait_trig(1, 300, n);
      chk("trig_rise", trig, 1);
      chk("busy_in_trig", busy, 1);
      wait_trig(0, 2000, n);
      chk("trig_width", n, 1000);
      repeat (2000) @(negedge inclk);
      echo = 1;
      repeat (1000) @(negedge inclk);
      start = 1;
      @(negedge inclk);
      start = 0;
      chk("busy_in_measure", busy, 1);
      chk("no_done_in_measure", done, 0);
      repeat (4799) @(negedge inclk);
      echo = 0;
      wait_done(500, n);
      chk("done_normal", done, 1);
      chk_rng("echo_us_normal", echo_us, 57, 58);
      chk("timeout_normal", timeout, 0);
      @(negedge inclk);
      chk("done_one_cycle", done, 0);
      start = 1;
      @(negedge inclk);
      start = 0;
      wait_idle();
      seen = 0;
      repeat (500) begin
         @(negedge inclk);
         if (trig === 1'b1) seen++;
      end
      chk("start_while_busy_ignored", seen, 0);
      chk_rng("echo_us_held", echo_us, 57, 58);
      // no echo: WAIT_RISE times out
      pulse_start();
      wait_trig(1, 300, n);
      chk("noecho_trig_rise", trig, 1);
      wait_trig(0, 2000, n);
      wait_done(12000, n);
      chk("noecho_done", done, 1);
      chk("noecho_latency", n, 10000);
      chk("noecho_timeout", timeout, 1);
      chk("noecho_echo_us", echo_us, 0);
      wait_idle();
      // stuck echo, already high when WAIT_RISE is entered
      pulse_start();
      wait_trig(1, 300, n);
      repeat (500) @(negedge inclk);
      echo = 1;
      wait_trig(0, 2000, n);
      wait_done(12000, n);
      chk("stuck_done", done, 1);
      chk("stuck_latency", n, 10000);
      chk("stuck_echo_us", echo_us, 100);
      chk("stuck_timeout", timeout, 1);
      echo = 0;
      wait_idle();
      // reset in the middle of the trigger pulse
      pulse_start();
      wait_trig(1, 300, n);
      repeat (300) @(negedge inclk);
      chk("pre_rst_trig", trig, 1);
      #2 rst = 1;
      #1;
      chk("async_rst_trig", trig, 0);
      chk("async_rst_busy", busy, 0);
      repeat (3) @(negedge inclk);
      rst = 0;
      seen = 0;
      repeat (2000) begin
         @(negedge inclk);
         if (trig === 1'b1 || done === 1'b1) seen++;
      end
      chk("no_activity_after_rst", seen, 0);
      chk("rst_clears_echo_us", echo_us, 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
